// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, output-slot state type and byte-lane mapping for the packer family
package conv_pkg;
  localparam int BYTE_W = 8;
  localparam int MAX_BYTES = 8;
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;
  function automatic int lane_of(input int k, input int num_bytes, input bit msb_first);
    return msb_first ? num_bytes - 1 - k : k;
  endfunction
endpackage

// File: rtl/conv_out_slot.sv
// conv_out_slot: one-word registered output slot with valid/ready handshake and same-cycle drain/reload
import conv_pkg::*;
module conv_out_slot #(
  parameter int W = 32
) (
  input  logic         PCLK,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic [3:0]   load_bytes,
  input  logic         READY_OUT,
  output logic [W-1:0] DATA_OUT,
  output logic [3:0]   BYTES_OUT,
  output logic         VALID_OUT,
  output logic         free
);
  slot_state_e state_q, state_d;
  assign VALID_OUT = state_q == SLOT_FULL;
  assign free = !VALID_OUT || READY_OUT;
  // a load always fills the slot; otherwise a taken word empties it
  always_comb begin
    state_d = load ? SLOT_FULL : (READY_OUT ? SLOT_EMPTY : state_q);
  end
  // slot state register
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) state_q <= SLOT_EMPTY;
    else state_q <= state_d;
  end
  // word and byte count only change on a load, so they hold steady under backpressure
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      DATA_OUT <= '0;
      BYTES_OUT <= '0;
    end else if (load) begin
      DATA_OUT <= load_data;
      BYTES_OUT <= load_bytes;
    end
  end
endmodule

// File: rtl/conv_8_to_n.sv
// conv_8_to_n: packs bytes into NUM_BYTES-wide words; CONV_FLUSH_EN enables partial-word flush
import conv_pkg::*;
module conv_8_to_n #(
  parameter int NUM_BYTES = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                        PCLK,
  input  logic                        RESET,
  input  logic [BYTE_W-1:0]           DATA_IN,
  input  logic                        VALID_IN,
  output logic                        READY_IN,
  input  logic                        FLUSH,
  output logic [BYTE_W*NUM_BYTES-1:0] DATA_OUT,
  output logic                        VALID_OUT,
  input  logic                        READY_OUT,
  output logic [3:0]                  BYTES_OUT
);
  localparam int W = BYTE_W * NUM_BYTES;
  localparam logic [2:0] LAST = 3'(NUM_BYTES - 1);
  logic [W-1:0] asm_q, asm_byte;
  logic [2:0]   cnt_q;
  logic         accept, complete, service, load, free;
  logic [3:0]   load_bytes;
  int           lane;
  assign READY_IN = !(cnt_q == LAST && !free);
  assign accept = VALID_IN && READY_IN;
  assign complete = accept && cnt_q == LAST;
  assign load = complete || service;
  assign load_bytes = complete ? 4'(NUM_BYTES) : 4'(cnt_q) + {3'b0, accept};
  // assembly register with this cycle's byte merged into its lane
  always_comb begin
    lane = lane_of(int'(cnt_q), NUM_BYTES, MSB_FIRST != 0);
    asm_byte = asm_q;
    if (accept) asm_byte[lane*BYTE_W +: BYTE_W] = DATA_IN;
  end
  // byte count and assembly register; both restart whenever a word leaves for the slot
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= accept ? cnt_q + 3'd1 : cnt_q;
      asm_q <= asm_byte;
    end
  end
`ifdef CONV_FLUSH_EN
  logic pend_q, flush_req, pend_d;
  assign flush_req = FLUSH || pend_q;
  assign service = flush_req && (cnt_q != 0 || accept) && free && !complete;
  assign pend_d = flush_req && !(complete || service || (cnt_q == 0 && !accept));
  // pending flush survives until a word leaves or there is nothing to flush
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) pend_q <= 1'b0;
    else pend_q <= pend_d;
  end
`else
  logic unused_flush;
  assign unused_flush = FLUSH;
  assign service = 1'b0;
`endif
  conv_out_slot #(.W(W)) u_slot (
    .PCLK(PCLK),
    .RESET(RESET),
    .load(load),
    .load_data(asm_byte),
    .load_bytes(load_bytes),
    .READY_OUT(READY_OUT),
    .DATA_OUT(DATA_OUT),
    .BYTES_OUT(BYTES_OUT),
    .VALID_OUT(VALID_OUT),
    .free(free)
  );
endmodule

// File: tb/tb_conv_8_to_n.sv
// tb_conv_8_to_n: directed vectors for conv_8_to_n (flush cases built when CONV_FLUSH_EN is defined)
module tb_conv_8_to_n;
  logic        PCLK = 0, RESET = 1, VALID_IN = 0, FLUSH = 0, READY_OUT = 1;
  logic [7:0]  DATA_IN = 0;
  logic        rdy_a, rdy_b, rdy_c, vld_a, vld_b, vld_c;
  logic [31:0] dat_a, dat_b;
  logic [15:0] dat_c;
  logic [3:0]  cnt_a, cnt_b, cnt_c;
  int          n_vec = 0, n_err = 0;
  always #5 PCLK = ~PCLK;
  conv_8_to_n #(.NUM_BYTES(4), .MSB_FIRST(1)) u_a (.PCLK(PCLK), .RESET(RESET), .DATA_IN(DATA_IN),
    .VALID_IN(VALID_IN), .READY_IN(rdy_a), .FLUSH(FLUSH), .DATA_OUT(dat_a), .VALID_OUT(vld_a),
    .READY_OUT(READY_OUT), .BYTES_OUT(cnt_a));
  conv_8_to_n #(.NUM_BYTES(4), .MSB_FIRST(0)) u_b (.PCLK(PCLK), .RESET(RESET), .DATA_IN(DATA_IN),
    .VALID_IN(VALID_IN), .READY_IN(rdy_b), .FLUSH(FLUSH), .DATA_OUT(dat_b), .VALID_OUT(vld_b),
    .READY_OUT(READY_OUT), .BYTES_OUT(cnt_b));
  conv_8_to_n #(.NUM_BYTES(2), .MSB_FIRST(1)) u_c (.PCLK(PCLK), .RESET(RESET), .DATA_IN(DATA_IN),
    .VALID_IN(VALID_IN), .READY_IN(rdy_c), .FLUSH(FLUSH), .DATA_OUT(dat_c), .VALID_OUT(vld_c),
    .READY_OUT(READY_OUT), .BYTES_OUT(cnt_c));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    VALID_IN = 1;
    DATA_IN = b;
    tick();
    VALID_IN = 0;
  endtask
  initial begin
    tick();
    tick();
    RESET = 0;
    tick();
    chk("rst_data", dat_a, 0);
    chk("rst_bytes", cnt_a, 0);
    chk("rst_valid", vld_a, 0);
    chk("rst_ready", rdy_a, 1);
    send(8'h00);
    send(8'h04);
    chk("nb2_w0", dat_c, 16'h0004);
    chk("nb2_v0", vld_c, 1);
    chk("nb4_nov", vld_a, 0);
    send(8'h08);
    chk("nb2_drain", vld_c, 0);
    send(8'h0C);
    chk("msb_word", dat_a, 32'h0004080C);
    chk("msb_bytes", cnt_a, 4);
    chk("msb_valid", vld_a, 1);
    chk("lsb_word", dat_b, 32'h0C080400);
    chk("nb2_w1", dat_c, 16'h080C);
    chk("nb2_bytes", cnt_c, 2);
    tick();
    chk("msb_one_cyc", vld_a, 0);
    send(8'h10);
    send(8'h14);
    chk("nb2_1014", dat_c, 16'h1014);
    send(8'h18);
    send(8'h1C);
    chk("msb_word2", dat_a, 32'h1014181C);
    tick();
    READY_OUT = 0;
    send(8'h00);
    send(8'h04);
    send(8'h08);
    send(8'h0C);
    chk("bp_held_v", vld_a, 1);
    send(8'h10);
    send(8'h14);
    send(8'h18);
    chk("bp_ready_lo", rdy_a, 0);
    VALID_IN = 1;
    DATA_IN = 8'h1C;
    tick();
    tick();
    chk("bp_stable", dat_a, 32'h0004080C);
    chk("bp_ready_lo2", rdy_a, 0);
    READY_OUT = 1;
    #1;
    chk("bp_ready_comb", rdy_a, 1);
    chk("bp_first", dat_a, 32'h0004080C);
    tick();
    VALID_IN = 0;
    chk("bp_second", dat_a, 32'h1014181C);
    chk("bp_second_v", vld_a, 1);
    tick();
    chk("bp_empty", vld_a, 0);
`ifdef CONV_FLUSH_EN
    send(8'h20);
    send(8'h24);
    FLUSH = 1;
    tick();
    FLUSH = 0;
    chk("fl_word", dat_a, 32'h20240000);
    chk("fl_bytes", cnt_a, 2);
    chk("fl_valid", vld_a, 1);
    tick();
    FLUSH = 1;
    tick();
    FLUSH = 0;
    chk("fl_cnt0", vld_a, 0);
    send(8'h50);
    chk("fl_pend_clr", vld_a, 0);
    send(8'h54);
    send(8'h58);
    send(8'h5C);
    chk("fl_after", dat_a, 32'h5054585C);
    READY_OUT = 0;
    send(8'h60);
    send(8'h64);
    send(8'h68);
    send(8'h6C);
    send(8'h70);
    FLUSH = 1;
    tick();
    FLUSH = 0;
    tick();
    chk("fl_stall_hold", dat_a, 32'h6064686C);
    READY_OUT = 1;
    tick();
    chk("fl_stall_word", dat_a, 32'h70000000);
    chk("fl_stall_bytes", cnt_a, 1);
    chk("fl_stall_v", vld_a, 1);
    tick();
    send(8'h80);
    send(8'h84);
    send(8'h88);
    FLUSH = 1;
    send(8'h8C);
    FLUSH = 0;
    chk("fl_full_word", dat_a, 32'h8084888C);
    chk("fl_full_bytes", cnt_a, 4);
    tick();
    chk("fl_full_once", vld_a, 0);
`else
    send(8'h20);
    send(8'h24);
    FLUSH = 1;
    tick();
    FLUSH = 0;
    chk("nofl_ignored", vld_a, 0);
    send(8'h28);
    send(8'h2C);
    chk("nofl_word", dat_a, 32'h2024282C);
    chk("nofl_bytes", cnt_a, 4);
    tick();
`endif
    READY_OUT = 0;
    send(8'hB0);
    send(8'hB4);
    send(8'hB8);
    send(8'hBC);
    send(8'hA0);
    send(8'hA4);
    send(8'hA8);
    chk("pre_rst_v", vld_a, 1);
    RESET = 1;
    #1;
    chk("mid_rst_data", dat_a, 0);
    chk("mid_rst_bytes", cnt_a, 0);
    chk("mid_rst_valid", vld_a, 0);
    chk("mid_rst_ready", rdy_a, 1);
    tick();
    RESET = 0;
    READY_OUT = 1;
    send(8'h40);
    send(8'h44);
    send(8'h48);
    chk("post_rst_nov", vld_a, 0);
    send(8'h4C);
    chk("post_rst_word", dat_a, 32'h4044484C);
    chk("post_rst_bytes", cnt_a, 4);
    chk("post_rst_v", vld_a, 1);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/conv_8_to_n.md
# conv_8_to_n

Parametrised byte-to-word packer that collects 8-bit bytes into words of NUM_BYTES bytes for the serial receive path. It supersedes the fixed 8→32 and 8→16 converters: one block, any width from 16 to 64 bits. It adds a valid/ready handshake on both sides, a one-word output slot with backpressure, selectable byte order and optional partial-word flush. It sits between the byte-wide deserialiser output and the word-wide consumer, all on PCLK.

## Interface
- NUM_BYTES, 4: bytes per output word; legal 2..8.
- MSB_FIRST, 1: 1 = first accepted byte lands in the most-significant byte; 0 = first byte lands in the least-significant byte.
- PCLK  in  1  sole clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- DATA_IN  in  8  input byte.
- VALID_IN  in  1  DATA_IN is valid this cycle.
- READY_IN  out  1  block accepts a byte this cycle; a byte is transferred when VALID_IN && READY_IN.
- FLUSH  in  1  request to emit the current partial word.
- DATA_OUT  out  8*NUM_BYTES  assembled word.
- VALID_OUT  out  1  DATA_OUT/BYTES_OUT hold a word.
- READY_OUT  in  1  consumer takes the word when VALID_OUT && READY_OUT.
- BYTES_OUT  out  4  number of real bytes in DATA_OUT (1..NUM_BYTES).

## Operation
- State:
  - assembly register ASM (8*NUM_BYTES bits);
  - byte counter CNT, range 0..NUM_BYTES-1;
  - output slot: DATA_OUT, BYTES_OUT and VALID_OUT, with states EMPTY and FULL;
  - FLUSH_PEND flag.
- Byte placement:
  - The byte accepted at count k goes to lane NUM_BYTES-1-k when MSB_FIRST=1.
  - It goes to lane k when MSB_FIRST=0.
- Accept without completion: with CNT < NUM_BYTES-1, the byte is written into ASM and CNT increments.
- Accept with completion: with CNT = NUM_BYTES-1, the completed word (ASM plus this byte) loads the slot, BYTES_OUT=NUM_BYTES, CNT→0 and ASM clears to 0.
- Slot free: the slot is free when it is EMPTY, or when it is FULL with READY_OUT=1 in the same cycle (drain and reload together).
- READY_IN = 0 only when CNT = NUM_BYTES-1 and the slot is not free. Otherwise it is 1. This gives a combinational path from READY_OUT.
- Slot transitions:
  - EMPTY→FULL on a load.
  - FULL→EMPTY on a drain with no load.
  - FULL→FULL on a drain with a load.
- Flush:
  - A FLUSH pulse sets FLUSH_PEND; the flag stays set until serviced.
  - Service condition: FLUSH_PEND or FLUSH is set, CNT>0 or a byte is accepted that cycle, the slot is free, and no word completes that cycle.
  - On service, ASM (including any byte accepted that cycle) loads the slot with unfilled lanes zero, BYTES_OUT = bytes held, CNT→0, and FLUSH_PEND clears.
  - FLUSH with CNT=0 and no byte accepted: no word is emitted and FLUSH_PEND clears.
  - If a word completes in the same cycle as a flush request, the full word is emitted and the flush is satisfied (FLUSH_PEND clears).
- Reset (any time, including mid-word or with the slot full):
  - ASM=0, CNT=0, FLUSH_PEND=0.
  - DATA_OUT=0, BYTES_OUT=0, VALID_OUT=0.
  - READY_IN=1.
  - A partial word is discarded and nothing is emitted.

## Timing
- Throughput: one byte per PCLK while READY_IN=1. One word per NUM_BYTES cycles is sustained with READY_OUT held high, with no bubbles.
- Latency: VALID_OUT rises on the PCLK edge that accepts the final byte, i.e. it is registered and visible the cycle after that byte is presented.
- Flush latency: a word appears one edge after the service cycle.
- Slot outputs are stable while VALID_OUT=1 and READY_OUT=0.
- Every output except READY_IN comes from a register.

## Configuration
- CONV_FLUSH_EN defined: FLUSH, FLUSH_PEND and partial-word emission are present as described above.
- CONV_FLUSH_EN undefined:
  - FLUSH is ignored and FLUSH_PEND is removed.
  - Only full words are emitted.
  - BYTES_OUT is held at NUM_BYTES after the first word (0 out of reset).

## Structure
- Package conv_pkg holds:
  - BYTE_W=8 and MAX_BYTES=8;
  - the slot state enum {SLOT_EMPTY, SLOT_FULL};
  - a lane-index function lane_of(k, NUM_BYTES, MSB_FIRST).
- One sub-module, conv_out_slot, is the output register with its valid/ready handshake and load/drain logic. It is reusable by the later word-to-byte unpacker.

## Test plan
- NUM_BYTES=4, MSB_FIRST=1, bytes 0x00,0x04,0x08,0x0C on consecutive cycles, READY_OUT=1 → DATA_OUT=0x0004080C, BYTES_OUT=4, VALID_OUT high for exactly one cycle.
- Same stream with MSB_FIRST=0 → DATA_OUT=0x0C080400. With NUM_BYTES=2 and MSB_FIRST=1, bytes 0x10,0x14 → DATA_OUT=0x1014.
- NUM_BYTES=4, READY_OUT=0, send 8 bytes 0x00..0x1C step 4:
  - First word 0x0004080C is held.
  - READY_IN drops while the second word waits at CNT=3.
  - Raising READY_OUT gives 0x0004080C, then 0x1014181C.
  - No byte is lost or duplicated.
- CONV_FLUSH_EN, bytes 0x20,0x24 then FLUSH → DATA_OUT=0x20240000, BYTES_OUT=2. FLUSH asserted with CNT=0 → no VALID_OUT.
- FLUSH pulsed while the slot is FULL and stalled → word emitted only after the drain. FLUSH pulsed together with the 4th byte → one full word, BYTES_OUT=4.
- RESET asserted mid-word after 3 bytes → all outputs 0 immediately. The next 4 bytes 0x40,0x44,0x48,0x4C → 0x4044484C.
